// File: rtl/deser_pkg.sv
// Shared types and width helpers for the serial-to-parallel deserializer.
package deser_pkg;

  typedef enum logic {
    HUNT  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Bit counter width; must index positions 0..n-1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // FIFO read/write pointer width; pointers wrap naturally for power-of-two depths.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/deser_if.sv
// Output word stream: valid/ready handshake with the FIFO head word.
interface deser_if #(
  parameter int N = 8
);
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;

  modport master (output out_valid, output out_data, input  out_ready);
  modport slave  (input  out_valid, input  out_data, output out_ready);
endinterface

// File: rtl/deser_fifo.sv
// First-word-fall-through FIFO buffering completed words. A pop in the same
// cycle as a push to a full FIFO frees the slot first, so the push lands.
module deser_fifo
  import deser_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int PW = ptr_width(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [LW-1:0] count;
  logic          pop_ok;
  logic          push_ok;

  assign empty    = (count == '0);
  assign full     = (count == LW'(DEPTH));
  assign pop_ok   = pop && !empty;
  assign push_ok  = push && (!full || pop_ok);
  assign pop_data = mem[rd_ptr];
  assign level    = count;

  // Storage; cleared on reset so the head word reads zero out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/deser_stream.sv
// Serial-to-parallel deserializer with frame alignment, per-word bit order
// and a buffered valid/ready output.
//
//   state | meaning
//   HUNT  | waiting for the first sof; non-sof bits are dropped
//   SHIFT | assembling words, cnt = arrival index of the next bit
module deser_stream
  import deser_pkg::*;
#(
  parameter int N         = 8,
  parameter int DEPTH     = 2,
  parameter bit SYNC_MODE = 1'b0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       bit_valid,
  input  logic                       bit_in,
  input  logic                       sof,
  input  logic                       msb_first,
  deser_if.master                    out_if,
  output logic                       overflow,
  input  logic                       clear_ovf,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int     CW         = cnt_width(N);
  localparam state_t RESET_STATE = SYNC_MODE ? HUNT : SHIFT;

  state_t        state_q, state_d;
  logic          take_bit;
  logic [CW-1:0] cnt_q;
  logic          ord_q;
  logic [N-1:0]  shreg_q, shreg_d;
  logic          word_start;
  logic [CW-1:0] k;
  logic          ord;
  logic [CW-1:0] pos;
  logic          complete;
  logic          fifo_full;
  logic          fifo_empty;
  logic          pop;
  logic          drop;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= RESET_STATE;
    else       state_q <= state_d;
  end

  // Next state and bit qualification: in HUNT only an sof bit is accepted.
  always_comb begin
    state_d  = state_q;
    take_bit = 1'b0;
    case (state_q)
      HUNT: begin
        if (bit_valid && sof) begin
          take_bit = 1'b1;
          state_d  = SHIFT;
        end
      end
      SHIFT: take_bit = bit_valid;
      default: state_d = RESET_STATE;
    endcase
  end

  // Bit placement; sof restarts the word and re-latches the bit order.
  always_comb begin
    word_start = sof || (cnt_q == '0);
    k          = word_start ? '0 : cnt_q;
    ord        = word_start ? msb_first : ord_q;
    pos        = ord ? (CW'(N-1) - k) : k;
    shreg_d    = shreg_q;
    shreg_d[pos] = bit_in;
    complete   = take_bit && (k == CW'(N-1));
  end

  // Counter, order latch and shift register advance only on accepted bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      ord_q   <= 1'b0;
      shreg_q <= '0;
    end else if (take_bit) begin
      cnt_q   <= complete ? '0 : (k + CW'(1));
      ord_q   <= ord;
      shreg_q <= shreg_d;
    end
  end

  assign pop              = out_if.out_ready && !fifo_empty;
  assign drop             = complete && fifo_full && !pop;
  assign out_if.out_valid = !fifo_empty;

  // Sticky overflow; a new drop takes priority over a clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          overflow <= 1'b0;
    else if (drop)      overflow <= 1'b1;
    else if (clear_ovf) overflow <= 1'b0;
  end

  deser_fifo #(
    .W     (N),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (complete),
    .push_data (shreg_d),
    .pop       (out_if.out_ready),
    .pop_data  (out_if.out_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (level)
  );

endmodule
